// File: rtl/phy_rx_block_lock.sv
// ---------------------------------------------------------------------------
// phy_rx_block_lock
//
// Block-lock controller for the 64B66B receive path. It watches the 2-bit
// sync headers coming out of the GT RX gearbox. While unlocked, every invalid
// header causes a one-cycle gearbox slip request, followed by a quiet period
// that lets the GT realign. Once SH_CNT_MAX consecutive valid headers have
// been seen, block lock is declared. While locked, headers are checked in
// windows of SH_CNT_MAX. If SH_INVALID_MAX invalid headers land in one
// window, lock is dropped and a slip is issued.
//
// Ports
//   i_rx_clk          RX user clock
//   i_rx_rst          asynchronous, active-high reset
//   i_rx_header       sync header from the GT gearbox
//   i_rx_header_valid qualifier for i_rx_header
//   i_rx_valid        GT data valid (0 while the gearbox pauses)
//   o_rx_slip         one-cycle gearbox slip request
//   o_block_lock      block lock achieved
//   o_rx_data_valid   i_rx_valid delayed one cycle, gated by o_block_lock
//   o_slip_cnt        total slips issued (saturating)
//   o_lock_loss_cnt   locked-to-unlocked transitions (saturating)
// ---------------------------------------------------------------------------
module phy_rx_block_lock #(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32,
    parameter int CNT_W          = 16
) (
    input  logic             i_rx_clk,
    input  logic             i_rx_rst,
    input  logic [1:0]       i_rx_header,
    input  logic             i_rx_header_valid,
    input  logic             i_rx_valid,
    output logic             o_rx_slip,
    output logic             o_block_lock,
    output logic             o_rx_data_valid,
    output logic [CNT_W-1:0] o_slip_cnt,
    output logic [CNT_W-1:0] o_lock_loss_cnt
);

    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    // Terminal values are compared against the registered count, so the
    // event that brings a counter to its limit is detected without an adder
    // in the compare path.
    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX - 1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_LOCK_INIT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    // A sync header is valid when its two bits differ (2'b01 or 2'b10).
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic               hdr_ev_q, hdr_ev_d;
    logic               hdr_bad_q, hdr_bad_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]   sh_inv_q, sh_inv_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               lock_q, lock_d;
    logic               slip_q, slip_d;
    logic               dv_q, dv_d;
    logic [CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

    // Next-state, counter and registered-output logic for the lock FSM.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        sh_inv_d   = sh_inv_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        loss_cnt_d = loss_cnt_q;

        // Header pipeline stage: the FSM only ever looks at registered
        // header information, so i_rx_header never reaches an output
        // combinationally.
        hdr_ev_d  = i_rx_header_valid & i_rx_valid;
        hdr_bad_d = ~sh_is_valid(i_rx_header);

        case (state_q)
            ST_LOCK_INIT: begin
                lock_d   = 1'b0;
                sh_cnt_d = '0;
                sh_inv_d = '0;
                state_d  = ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (hdr_ev_q) begin
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                    if (hdr_bad_q) begin
                        sh_inv_d = sh_inv_q + INV_W'(1);
                    end else begin
                        sh_inv_d = sh_inv_q;
                    end
                    if (!lock_q) begin
                        if (hdr_bad_q) begin
                            state_d    = ST_SLIP;
                            slip_d     = 1'b1;
                            slip_cnt_d = sat_inc(slip_cnt_q);
                            lock_d     = 1'b0;
                        end else if (sh_cnt_q == SH_LAST) begin
                            lock_d   = 1'b1;
                            sh_cnt_d = '0;
                            sh_inv_d = '0;
                        end else begin
                            lock_d = 1'b0;
                        end
                    end else begin
                        // Too many invalid headers wins over a window end
                        // landing on the same header.
                        if (hdr_bad_q && (sh_inv_q == INV_LAST)) begin
                            state_d    = ST_SLIP;
                            slip_d     = 1'b1;
                            slip_cnt_d = sat_inc(slip_cnt_q);
                            loss_cnt_d = sat_inc(loss_cnt_q);
                            lock_d     = 1'b0;
                        end else if (sh_cnt_q == SH_LAST) begin
                            sh_cnt_d = '0;
                            sh_inv_d = '0;
                        end else begin
                            lock_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_TEST_SH;
                end
            end
            ST_SLIP: begin
                // o_rx_slip was raised on entry; leaving after one cycle
                // keeps it a single-cycle pulse.
                lock_d     = 1'b0;
                wait_cnt_d = '0;
                state_d    = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                lock_d = 1'b0;
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = ST_LOCK_INIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                lock_d  = 1'b0;
                state_d = ST_LOCK_INIT;
            end
        endcase

        dv_d = i_rx_valid & lock_d;
    end

    // State, header pipeline, counters and registered outputs.
    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state_q    <= ST_LOCK_INIT;
            hdr_ev_q   <= 1'b0;
            hdr_bad_q  <= 1'b0;
            sh_cnt_q   <= '0;
            sh_inv_q   <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
            dv_q       <= 1'b0;
            slip_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_ev_q   <= hdr_ev_d;
            hdr_bad_q  <= hdr_bad_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_inv_q   <= sh_inv_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            dv_q       <= dv_d;
            slip_cnt_q <= slip_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_rx_slip       = slip_q;
    assign o_block_lock    = lock_q;
    assign o_rx_data_valid = dv_q;
    assign o_slip_cnt      = slip_cnt_q;
    assign o_lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_phy_rx_block_lock.sv
// ---------------------------------------------------------------------------
// Testbench for phy_rx_block_lock.
//
// The bench drives a main instance with the default parameters. It also
// drives a small instance (CNT_W=4, SLIP_WAIT=1) that is fed invalid headers
// all the time, so that its slip counter saturates. The main instance is
// checked every cycle against an event-level reference model. The bench
// also checks hand-computed values at the end of each table segment and in
// a few hand-written sequences.
// ---------------------------------------------------------------------------
module tb_phy_rx_block_lock;

    localparam int SH_MAX  = 64;
    localparam int INV_MAX = 16;
    localparam int SW      = 32;
    localparam int CW      = 16;
    localparam int SAT     = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [1:0]    hdr;
    logic          hv;
    logic          v;
    logic          slip;
    logic          lock;
    logic          dv;
    logic [CW-1:0] scnt;
    logic [CW-1:0] lcnt;

    logic [1:0]    hdr2;
    logic          hv2;
    logic          v2;
    logic          slip2;
    logic          lock2;
    logic          dv2;
    logic [3:0]    scnt2;
    logic [3:0]    lcnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (event level: a header counts only if its
    // cycle is at or after m_active).
    bit m_locked;
    int m_sh, m_inv, m_scnt, m_lcnt, m_active, m_cyc;
    // Outputs that the model predicts for the next observed cycle.
    bit d_slip, d_lock;
    int d_scnt, d_lcnt;

    phy_rx_block_lock #(
        .SH_CNT_MAX(SH_MAX), .SH_INVALID_MAX(INV_MAX), .SLIP_WAIT(SW), .CNT_W(CW)
    ) dut (
        .i_rx_clk(clk), .i_rx_rst(rst), .i_rx_header(hdr),
        .i_rx_header_valid(hv), .i_rx_valid(v), .o_rx_slip(slip),
        .o_block_lock(lock), .o_rx_data_valid(dv), .o_slip_cnt(scnt),
        .o_lock_loss_cnt(lcnt)
    );

    phy_rx_block_lock #(
        .SH_CNT_MAX(4), .SH_INVALID_MAX(2), .SLIP_WAIT(1), .CNT_W(4)
    ) dut_small (
        .i_rx_clk(clk), .i_rx_rst(rst), .i_rx_header(hdr2),
        .i_rx_header_valid(hv2), .i_rx_valid(v2), .o_rx_slip(slip2),
        .o_block_lock(lock2), .o_rx_data_valid(dv2), .o_slip_cnt(scnt2),
        .o_lock_loss_cnt(lcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_sh = 0; m_inv = 0; m_scnt = 0; m_lcnt = 0;
        m_active = 0; m_cyc = 0;
        d_slip = 1'b0; d_lock = 1'b0; d_scnt = 0; d_lcnt = 0;
    endtask

    // Apply the rules to the header of cycle m_cyc. The results become
    // visible two cycles later, which is the next observation.
    task automatic model_decide(input logic [1:0] h, input logic hvi, input logic vi);
        bit bad;
        bit do_slip;
        do_slip = 1'b0;
        if (hvi && vi && (m_cyc >= m_active)) begin
            bad = (h == 2'b00) || (h == 2'b11);
            m_sh++;
            if (bad) m_inv++;
            if (!m_locked) begin
                if (bad) do_slip = 1'b1;
                else if (m_sh == SH_MAX) begin
                    m_locked = 1'b1; m_sh = 0; m_inv = 0;
                end
            end else if (m_inv == INV_MAX) begin
                if (m_lcnt < SAT) m_lcnt++;
                do_slip = 1'b1;
            end else if (m_sh == SH_MAX) begin
                m_sh = 0; m_inv = 0;
            end
        end
        if (do_slip) begin
            m_locked = 1'b0; m_sh = 0; m_inv = 0;
            if (m_scnt < SAT) m_scnt++;
            // Slip shows at m_cyc+2, the wait covers SW cycles, and
            // LOCK_INIT takes one more.
            m_active = m_cyc + SW + 3;
        end
        d_slip = do_slip; d_lock = m_locked; d_scnt = m_scnt; d_lcnt = m_lcnt;
        m_cyc++;
    endtask

    // Drive one cycle, compare the outputs after the edge with the model,
    // then let the model consume this cycle's header.
    task automatic step(input logic [1:0] h, input logic hvi, input logic vi);
        hdr = h; hv = hvi; v = vi;
        @(posedge clk);
        #1;
        check("slip", slip, d_slip);
        check("lock", lock, d_lock);
        check("data_valid", dv, vi & d_lock);
        check("slip_cnt", scnt, d_scnt);
        check("loss_cnt", lcnt, d_lcnt);
        model_decide(h, hvi, vi);
    endtask

    task automatic do_reset();
        hdr = 2'b00; hv = 1'b0; v = 1'b0;
        rst = 1'b1;
        #2;
        check("reset_slip", slip, 0);
        check("reset_lock", lock, 0);
        check("reset_dv", dv, 0);
        check("reset_slip_cnt", scnt, 0);
        check("reset_loss_cnt", lcnt, 0);
        check("reset_small_slip_cnt", scnt2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] hdr;
        logic       hv;
        logic       v;
        int         n;
        logic       e_slip;
        logic       e_lock;
        logic       e_dv;
        int         e_scnt;
        int         e_lcnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [1:0] rh;
        logic       rhv, rv;
        int         pbad;

        rst = 1'b1;
        hdr = 2'b00; hv = 1'b0; v = 1'b0;
        hdr2 = 2'b11; hv2 = 1'b1; v2 = 1'b1;
        model_reset();

        // Segments run back to back after reset. Expected values are the
        // outputs seen after the last cycle of each segment.
        // Five bad attempts (slip every 35 cycles), lock on 2'b10, then
        // 15 invalids (held), and 16 invalids in the next window (lost).
        tbl[0]  = '{2'b00, 1'b1, 1'b1,  2, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[1]  = '{2'b00, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[2]  = '{2'b00, 1'b1, 1'b1, 34, 1'b1, 1'b0, 1'b0, 2, 0};
        tbl[3]  = '{2'b00, 1'b1, 1'b1, 35, 1'b1, 1'b0, 1'b0, 3, 0};
        tbl[4]  = '{2'b00, 1'b1, 1'b1, 35, 1'b1, 1'b0, 1'b0, 4, 0};
        tbl[5]  = '{2'b00, 1'b1, 1'b1, 35, 1'b1, 1'b0, 1'b0, 5, 0};
        tbl[6]  = '{2'b10, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 5, 0};
        tbl[7]  = '{2'b10, 1'b1, 1'b1, 96, 1'b0, 1'b0, 1'b0, 5, 0};
        tbl[8]  = '{2'b10, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1, 5, 0};
        tbl[9]  = '{2'b00, 1'b1, 1'b1, 15, 1'b0, 1'b1, 1'b1, 5, 0};
        tbl[10] = '{2'b10, 1'b1, 1'b1, 48, 1'b0, 1'b1, 1'b1, 5, 0};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b1, 5, 0};
        tbl[12] = '{2'b00, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b0, 6, 1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].hdr, tbl[i].hv, tbl[i].v);
            check($sformatf("tbl%0d_slip", i), slip, tbl[i].e_slip);
            check($sformatf("tbl%0d_lock", i), lock, tbl[i].e_lock);
            check($sformatf("tbl%0d_dv", i), dv, tbl[i].e_dv);
            check($sformatf("tbl%0d_slip_cnt", i), scnt, tbl[i].e_scnt);
            check($sformatf("tbl%0d_loss_cnt", i), lcnt, tbl[i].e_lcnt);
        end

        // Gearbox pause: header events only on odd cycles. The relock needs
        // 64 events, which takes 128 cycles.
        for (int k = 0; k < 160; k++) step(2'b10, 1'b1, 1'(k % 2));
        check("pause_lock_before", lock, 0);
        step(2'b10, 1'b1, 1'b0);
        check("pause_lock_after", lock, 1);
        check("pause_dv_low", dv, 0);
        step(2'b10, 1'b1, 1'b1);
        check("pause_dv_high", dv, 1);
        for (int k = 162; k < 262; k++) step(2'b10, 1'b1, 1'(k % 2));
        check("pause_lock_held", lock, 1);

        // Reset in the middle of the post-slip wait.
        do_reset();
        for (int k = 0; k < 12; k++) step(2'b00, 1'b1, 1'b1);
        check("rstwait_pre_slip_cnt", scnt, 1);
        do_reset();
        for (int k = 0; k < 65; k++) begin
            step(2'b01, 1'b1, 1'b1);
            if (k == 19) check("small_slip_cnt_20", scnt2, 5);
            if (k == 63) check("relock_before", lock, 0);
        end
        check("relock_after", lock, 1);
        check("relock_slips", scnt, 0);
        check("small_saturated", scnt2, 15);
        check("small_no_lock", lock2, 0);

        // Random traffic: clean phases let lock form, and noisy phases
        // cause lock loss and slips.
        for (int p = 0; p < 4; p++) begin
            pbad = (p % 2 == 0) ? 400 : 3;
            for (int k = 0; k < 700; k++) begin
                rh  = ($urandom_range(pbad - 1) == 0) ? ($urandom_range(1) == 1 ? 2'b11 : 2'b00)
                                                      : ($urandom_range(1) == 1 ? 2'b10 : 2'b01);
                rhv = ($urandom_range(15) != 0);
                rv  = ($urandom_range(15) != 0);
                step(rh, rhv, rv);
            end
        end
        check("small_saturated_hold", scnt2, 15);
        check("small_loss_cnt", lcnt2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
